// File: rtl/icache_sa.sv
// Set-associative instruction cache: zero-latency hit lookup, per-set round-robin
// victim selection, and a single-outstanding line-fill FSM with flush/abort.
module icache_sa #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       rd_ena,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       hit,
  output logic [31:0]                hit_data,
  output logic                       busy,
  output logic                       mem_rd_ena,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic                       mem_rd_done,
  input  logic [32*LINE_WORDS-1:0]   mem_rd_data
);

  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e state_q, state_d;
  logic   abort_q, abort_d;
  logic   mem_rd_ena_q, mem_rd_ena_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;

  logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d;
  logic [SETS-1:0][PTR_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0]  tags_q  [SETS][WAYS];
  logic [LINE_W-1:0] lines_q [SETS][WAYS];

  logic [IDX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [WSEL_W-1:0] rd_word;
  logic [WAYS-1:0]   hit_vec;
  logic [LINE_W-1:0] hit_line;
  logic [PTR_W-1:0]  vict_way;
  logic              vict_found;
  logic              miss_req;
  logic              fill_en;
  logic              unused_addr_lsb;

  assign rd_word = rd_addr[OFF_W-1:2];
  assign rd_idx  = rd_addr[OFF_W+IDX_W-1:OFF_W];
  assign rd_tag  = rd_addr[ADDR_W-1:OFF_W+IDX_W];
  assign unused_addr_lsb = ^rd_addr[1:0];

  // Lookup: at most one way can match, so OR-ing the matching lines is a clean mux.
  always_comb begin
    hit_vec  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[rd_idx][w] && (tags_q[rd_idx][w] == rd_tag);
      if (hit_vec[w]) hit_line = hit_line | lines_q[rd_idx][w];
    end
  end

  assign hit      = rd_ena && !flush && (|hit_vec);
  assign hit_data = hit_line[{rd_word, 5'b00000} +: 32];

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    vict_way   = ptr_q[miss_idx_q];
    vict_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vict_found && !valid_q[miss_idx_q][w]) begin
        vict_way   = PTR_W'(w);
        vict_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      abort_q       <= 1'b0;
      mem_rd_ena_q  <= 1'b0;
      mem_rd_addr_q <= '0;
      valid_q       <= '0;
      ptr_q         <= '0;
    end else begin
      state_q       <= state_d;
      abort_q       <= abort_d;
      mem_rd_ena_q  <= mem_rd_ena_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      valid_q       <= valid_d;
      ptr_q         <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    miss_idx_q <= miss_idx_d;
    miss_tag_q <= miss_tag_d;
    if (fill_en) begin
      tags_q[miss_idx_q][vict_way]  <= miss_tag_q;
      lines_q[miss_idx_q][vict_way] <= mem_rd_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (miss_req) state_d = S_WAIT;
      S_WAIT:  if (mem_rd_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A flush arriving with or before the response cancels the fill.
  always_comb begin
    miss_req      = (state_q == S_IDLE) && rd_ena && !hit && !flush;
    fill_en       = (state_q == S_WAIT) && mem_rd_done && !abort_q && !flush && !rst;
    busy          = (state_q == S_WAIT);
    mem_rd_ena_d  = miss_req;
    mem_rd_addr_d = miss_req ? {rd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : mem_rd_addr_q;
    miss_idx_d    = miss_req ? rd_idx : miss_idx_q;
    miss_tag_d    = miss_req ? rd_tag : miss_tag_q;
    abort_d       = abort_q;
    if (state_q == S_IDLE) begin
      abort_d = 1'b0;
    end else if (mem_rd_done) begin
      abort_d = 1'b0;
    end else if (flush) begin
      abort_d = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (fill_en) begin
      valid_d[miss_idx_q][vict_way] = 1'b1;
      if (vict_way == ptr_q[miss_idx_q]) begin
        ptr_d[miss_idx_q] = (WAYS > 1) ? ptr_q[miss_idx_q] + 1'b1 : '0;
      end
    end
    if (flush) valid_d = '0;
  end

  assign mem_rd_ena  = mem_rd_ena_q;
  assign mem_rd_addr = mem_rd_addr_q;

endmodule
